mux8to1: RTL and testbench
==========================

MUX8TO1 -- requirements
Module: mux8to1

Parameters
REQ-001 The block SHALL have parameter Q_RESET_VAL, default 1'b0, meaning the value loaded into cout_q on reset.

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all sequential logic on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in, input, 8 bits: data lanes in[0]..in[7].
REQ-005 The block SHALL have port sel, input, 3 bits: lane select, unsigned.
REQ-006 The block SHALL have port en, input, 1 bit: capture enable for cout_q.
REQ-007 The block SHALL have port cout, output, 1 bit: combinational selected lane.
REQ-008 The block SHALL have port cout_q, output, 1 bit: registered selected lane.
REQ-009 The block SHALL have port sel_q, output, 3 bits: sel value captured together with cout_q.

Function
REQ-010 cout SHALL equal in[sel] for all eight sel values 3'b000..3'b111, with zero clock latency.
REQ-011 cout SHALL be purely combinational and SHALL NOT depend on clk, rst_n or en.
REQ-012 cout SHALL be valid even when clk, rst_n and en are left unconnected.
REQ-013 cout SHALL be built as a three-level tree of seven 2:1 multiplexers:
- level 1: sel[0] picks from pairs (in[0],in[1]), (in[2],in[3]), (in[4],in[5]), (in[6],in[7]);
- level 2: sel[1] picks between the pair results;
- level 3: sel[2] gives the final output.
REQ-014 Each 2:1 stage SHALL output its first input when its select bit is 0 and its second input when it is 1.
REQ-015 The 2:1 stage SHALL be a separate reusable submodule instantiated seven times.
REQ-016 X/Z handling on sel or in SHALL follow the 2:1 stage's conditional-operator semantics; no extra X filtering.
REQ-017 cout SHALL follow any change on in or sel within the same simulation time step, with no glitch-suppression logic.
REQ-018 On each rising clk edge with rst_n=1 and en=1, cout_q SHALL load cout and sel_q SHALL load sel (one-cycle latency).
REQ-019 On a rising clk edge with en=0, cout_q and sel_q SHALL hold their values.
REQ-020 If en is X or Z, cout_q and sel_q SHALL hold their values.
REQ-021 When en=1 and in/sel change in the same cycle, cout_q SHALL capture the value of cout present just before the clock edge.

Reset
REQ-022 While rst_n=0, cout_q SHALL be Q_RESET_VAL and sel_q SHALL be 3'b000, immediately and without a clock edge.
REQ-023 Reset asserted mid-operation SHALL override en and clear cout_q and sel_q at once.
REQ-024 Reset SHALL NOT affect cout, which keeps tracking in[sel] throughout reset.
REQ-025 On reset release, the first rising edge with en=1 SHALL capture normally.

Verification
REQ-026 Combinational sweep: in=8'b11010101, clk/rst_n/en unconnected, sel stepped 0..7 at 10-time-unit intervals -> cout = 1,0,1,0,1,0,1,1.
REQ-027 Data-change test: sel=3'b011, in changes from 8'b11010101 to 8'b00001000 -> cout changes from 0 to 1 in the same time step.
REQ-028 Registered path: rst_n=1, en=1, in=8'hA5, sel=3'b111 -> after one rising edge, cout_q=1 and sel_q=3'b111.
REQ-029 Hold: en=0, sel changed to 3'b001 (cout=0) -> cout_q stays 1 and sel_q stays 3'b111 across 3 clock edges.
REQ-030 Async reset: rst_n dropped between clock edges -> cout_q=0 and sel_q=3'b000 immediately, while cout still equals in[sel].
REQ-031 Exhaustive check: all 256 values of in x 8 values of sel -> cout == in[sel] in every case.

Source files
------------

// File: rtl/mux8to1.sv
// ---------------------------------------------------------------------------
// mux8to1 -- 8:1 single-bit multiplexer with an optional registered copy.
//
// The combinational output is built from seven instances of the mux2 stage
// arranged as a three-level tree. A registered copy of the selected lane and
// the select value that produced it are captured when en is high.
//
// Ports (mux2):
//   a, b  : data inputs (a chosen when s=0, b chosen when s=1)
//   s     : select
//   y     : selected data
//
// Ports (mux8to1):
//   clk    : rising-edge clock for the capture registers
//   rst_n  : asynchronous active-low reset of cout_q / sel_q
//   in     : data lanes in[0]..in[7]
//   sel    : lane select, unsigned
//   en     : capture enable for cout_q / sel_q
//   cout   : combinational in[sel]
//   cout_q : registered in[sel]
//   sel_q  : sel value captured together with cout_q
// ---------------------------------------------------------------------------

module mux2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  // Conditional operator: an X/Z select merges a and b bitwise, which is the
  // intended X behaviour of the whole tree (no extra filtering anywhere).
  assign y = s ? b : a;

endmodule

module mux8to1 #(
  parameter logic Q_RESET_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in,
  input  logic [2:0] sel,
  input  logic       en,
  output logic       cout,
  output logic       cout_q,
  output logic [2:0] sel_q
);

  // Level 1: sel[0] picks within each adjacent lane pair.
  logic [3:0] lvl1;
  // Level 2: sel[1] picks between pair results.
  logic [1:0] lvl2;

  mux2 u_l1_0 (.a(in[0]), .b(in[1]), .s(sel[0]), .y(lvl1[0]));
  mux2 u_l1_1 (.a(in[2]), .b(in[3]), .s(sel[0]), .y(lvl1[1]));
  mux2 u_l1_2 (.a(in[4]), .b(in[5]), .s(sel[0]), .y(lvl1[2]));
  mux2 u_l1_3 (.a(in[6]), .b(in[7]), .s(sel[0]), .y(lvl1[3]));

  mux2 u_l2_0 (.a(lvl1[0]), .b(lvl1[1]), .s(sel[1]), .y(lvl2[0]));
  mux2 u_l2_1 (.a(lvl1[2]), .b(lvl1[3]), .s(sel[1]), .y(lvl2[1]));

  // Level 3: sel[2] chooses the lower or upper half.
  mux2 u_l3_0 (.a(lvl2[0]), .b(lvl2[1]), .s(sel[2]), .y(cout));

  // Capture registers. An X/Z en makes the if-condition false, so the
  // registers hold rather than pick up unknown data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout_q <= Q_RESET_VAL;
      sel_q  <= 3'b000;
    end else if (en) begin
      cout_q <= cout;
      sel_q  <= sel;
    end
  end

endmodule

// File: tb/tb_mux8to1.sv
// ---------------------------------------------------------------------------
// tb_mux8to1 -- self-checking bench for mux8to1.
// Reference: the selected lane is computed arithmetically as (in >> sel) & 1;
// the registers are modelled as two bench variables updated on each edge.
// ---------------------------------------------------------------------------

module tb_mux8to1;

  logic       clk;
  logic       rst_n;
  logic [7:0] in;
  logic [2:0] sel;
  logic       en;
  logic       cout;
  logic       cout_q;
  logic [2:0] sel_q;

  int n_checks;
  int n_fail;

  // Register model
  logic       mdl_q;
  logic [2:0] mdl_sel;

  mux8to1 #(.Q_RESET_VAL(1'b0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (in),
    .sel    (sel),
    .en     (en),
    .cout   (cout),
    .cout_q (cout_q),
    .sel_q  (sel_q)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic lane_of(input logic [7:0] d, input logic [2:0] s);
    logic [7:0] shifted;
    shifted = d >> s;
    return shifted[0];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t in=%b sel=%0d)", tag, obs, exp, $time, in, sel);
    end
  endtask

  initial begin : main
    logic [7:0] sweep_in;
    logic [7:0] sweep_exp;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    in    = 8'h00;
    sel   = 3'b000;
    mdl_q   = 1'b0;
    mdl_sel = 3'b000;
    #1;
    check("reset_cout_q", {7'b0, cout_q}, 8'h00);
    check("reset_sel_q", {5'b0, sel_q}, 8'h00);

    // Combinational sweep, registers held in reset.
    sweep_in  = 8'b11010101;
    sweep_exp = 8'b11010101;
    in = sweep_in;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      #10;
      check("sweep_cout", {7'b0, cout}, {7'b0, sweep_exp[i]});
    end

    // Data change with fixed select.
    sel = 3'b011;
    in  = 8'b11010101;
    #1;
    check("dchg_before", {7'b0, cout}, 8'h00);
    in = 8'b00001000;
    #1;
    check("dchg_after", {7'b0, cout}, 8'h01);

    // Exhaustive combinational check, also confirming reset holds.
    for (int d = 0; d < 256; d++) begin
      for (int s = 0; s < 8; s++) begin
        in  = 8'(d);
        sel = 3'(s);
        #1;
        check("exh_cout", {7'b0, cout}, {7'b0, lane_of(8'(d), 3'(s))});
      end
    end
    check("exh_reset_q", {5'b0, sel_q}, 8'h00);

    // Registered path.
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    in    = 8'hA5;
    sel   = 3'b111;
    @(posedge clk);
    #1;
    check("reg_cout_q", {7'b0, cout_q}, 8'h01);
    check("reg_sel_q", {5'b0, sel_q}, 8'h07);

    // Hold with en low.
    @(negedge clk);
    en  = 1'b0;
    sel = 3'b001;
    #1;
    check("hold_cout", {7'b0, cout}, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("hold_cout_q", {7'b0, cout_q}, 8'h01);
      check("hold_sel_q", {5'b0, sel_q}, 8'h07);
    end

    // Async reset between edges, en high during the following edge.
    @(negedge clk);
    en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cout_q", {7'b0, cout_q}, 8'h00);
    check("arst_sel_q", {5'b0, sel_q}, 8'h00);
    check("arst_cout", {7'b0, cout}, {7'b0, lane_of(in, sel)});
    @(posedge clk);
    #1;
    check("arst_override_q", {7'b0, cout_q}, 8'h00);
    check("arst_override_sel", {5'b0, sel_q}, 8'h00);

    // First enabled edge after release captures normally.
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    in    = 8'h40;
    sel   = 3'b110;
    @(posedge clk);
    #1;
    check("rel_cout_q", {7'b0, cout_q}, 8'h01);
    check("rel_sel_q", {5'b0, sel_q}, 8'h06);
    mdl_q   = 1'b1;
    mdl_sel = 3'b110;

    // Randomized traffic with occasional mid-cycle resets.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      in  = 8'($urandom_range(0, 255));
      sel = 3'($urandom_range(0, 7));
      en  = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 19) != 0);
      #1;
      if (!rst_n) begin
        mdl_q   = 1'b0;
        mdl_sel = 3'b000;
      end
      check("rnd_cout", {7'b0, cout}, {7'b0, lane_of(in, sel)});
      check("rnd_async_q", {7'b0, cout_q}, {7'b0, mdl_q});
      @(posedge clk);
      if (rst_n && en) begin
        mdl_q   = lane_of(in, sel);
        mdl_sel = sel;
      end
      #1;
      check("rnd_cout_q", {7'b0, cout_q}, {7'b0, mdl_q});
      check("rnd_sel_q", {5'b0, sel_q}, {5'b0, mdl_sel});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
